program_mem: RTL and testbench

- Synthesizable 16x8 program/data memory; the responder side of the control unit's fetch and store interface.
- Answers instruction fetches addressed by PC and accepts data stores from mmadr/mmwr.
- Contains a byte-serial boot loader that fills the array after reset while holding the CPU in reset, then releases it.
- Replaces the behavioural program-memory model used in simulation.

---
 rtl/pm_pkg.sv | 16 +
 rtl/program_mem_if.sv | 29 ++
 rtl/pm_ram.sv | 40 ++++
 rtl/program_mem.sv | 108 ++++++++++
 tb/tb_program_mem.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pm_pkg.sv
// rtl/pm_pkg.sv - shared types and constants for the program memory
package pm_pkg;

    localparam int PM_DEPTH = 16;
    localparam int PM_AW    = 4;
    localparam int PM_DW    = 8;

    localparam logic [PM_DW-1:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } pm_state_t;

endpackage

// File: rtl/program_mem_if.sv
// rtl/program_mem_if.sv - fetch/store bus between control unit and program memory
interface program_mem_if #(
    parameter int AW = pm_pkg::PM_AW,
    parameter int DW = pm_pkg::PM_DW
) ();

    logic [AW-1:0] PC;
    logic [DW-1:0] INSTRUCTION;
    logic [AW-1:0] mmadr_mem;
    logic          mmwr_mem;
    logic [DW-1:0] wdata_mem;

    modport master (
        output PC,
        output mmadr_mem,
        output mmwr_mem,
        output wdata_mem,
        input  INSTRUCTION
    );

    modport slave (
        input  PC,
        input  mmadr_mem,
        input  mmwr_mem,
        input  wdata_mem,
        output INSTRUCTION
    );

endinterface

// File: rtl/pm_ram.sv
// rtl/pm_ram.sv - DEPTH x DW array, one sync write port, one sync write-first read port
module pm_ram
    import pm_pkg::*;
#(
    parameter int DEPTH = PM_DEPTH,
    parameter int AW    = PM_AW,
    parameter int DW    = PM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // The array itself is never reset so contents survive a reset of the block.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= DW'(NOP_WORD);
        end else if (!rd_en) begin
            rdata <= DW'(NOP_WORD);
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/program_mem.sv
// rtl/program_mem.sv - program/data memory with byte-serial boot loader and CPU reset control
module program_mem
    import pm_pkg::*;
#(
    parameter int DEPTH    = PM_DEPTH,
    parameter int AW       = PM_AW,
    parameter int DW       = PM_DW,
    parameter int BOOT_LEN = PM_DEPTH
) (
    input  logic          clk_mem,
    input  logic          rstn_mem,
    program_mem_if.slave  bus,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          cpu_rst,
    output logic          boot_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(BOOT_LEN - 1);

    pm_state_t     state;
    logic [AW-1:0] load_ptr;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_rd_en;
    logic          ld_fire;

    assign ld_fire = ld_valid && ld_ready;

    // Handshake outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk_mem or negedge rstn_mem) begin
        if (!rstn_mem) begin
            state     <= LOAD;
            load_ptr  <= '0;
            ld_ready  <= 1'b1;
            cpu_rst   <= 1'b1;
            boot_done <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (ld_fire) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (load_ptr == LAST_IDX) begin
                            state    <= RELEASE;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    state     <= RUN;
                    cpu_rst   <= 1'b0;
                    boot_done <= 1'b1;
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state     <= LOAD;
                    load_ptr  <= '0;
                    ld_ready  <= 1'b1;
                    cpu_rst   <= 1'b1;
                    boot_done <= 1'b0;
                end
            endcase
        end
    end

    // Loader owns the write port while loading; the CPU store port owns it while running.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = load_ptr;
        ram_wdata = ld_data;
        unique case (state)
            LOAD: begin
                ram_we = ld_fire;
            end
            RUN: begin
                ram_we    = bus.mmwr_mem;
                ram_waddr = bus.mmadr_mem;
                ram_wdata = bus.wdata_mem;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    assign ram_rd_en = (state == RELEASE) || (state == RUN);

    pm_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk_mem),
        .rst_n (rstn_mem),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .rd_en (ram_rd_en),
        .raddr (bus.PC),
        .rdata (bus.INSTRUCTION)
    );

endmodule

// File: tb/tb_program_mem.sv
// tb/tb_program_mem.sv - randomized self-checking bench for program_mem
module tb_program_mem;
    import pm_pkg::*;

    logic       clk_mem;
    logic       rstn_mem;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       cpu_rst;
    logic       boot_done;

    program_mem_if bus ();

    program_mem dut (
        .clk_mem   (clk_mem),
        .rstn_mem  (rstn_mem),
        .bus       (bus.slave),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_rst   (cpu_rst),
        .boot_done (boot_done)
    );

    initial clk_mem = 1'b0;
    always #5 clk_mem = ~clk_mem;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: array contents, boot phase (0 loading, 1 release, 2 running), load pointer
    logic [7:0] m_mem [16];
    int         m_phase;
    int         m_ptr;
    logic [7:0] img [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock with the currently driven inputs and compare all outputs.
    task automatic step();
        logic [7:0] e_instr;
        e_instr = 8'h00;
        if (m_phase == 0) begin
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                m_ptr++;
                if (m_ptr == 16) begin
                    m_ptr   = 0;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            e_instr = m_mem[bus.PC];
            m_phase = 2;
        end else begin
            if (bus.mmwr_mem) m_mem[bus.mmadr_mem] = bus.wdata_mem;
            e_instr = m_mem[bus.PC];
        end
        @(posedge clk_mem);
        #1;
        check("instr", {24'h0, bus.INSTRUCTION}, {24'h0, e_instr});
        check("ld_ready", {31'h0, ld_ready}, {31'h0, m_phase == 0});
        check("cpu_rst", {31'h0, cpu_rst}, {31'h0, m_phase != 2});
        check("boot_done", {31'h0, boot_done}, {31'h0, m_phase == 2});
    endtask

    task automatic check_reset_outputs();
        check("rst_cpu_rst", {31'h0, cpu_rst}, 32'd1);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'd1);
        check("rst_boot_done", {31'h0, boot_done}, 32'd0);
        check("rst_instr", {24'h0, bus.INSTRUCTION}, 32'h0);
    endtask

    // Called 1 time unit after a rising edge; reset asserts mid-cycle.
    task automatic do_reset();
        ld_valid = 1'b0;
        rstn_mem = 1'b0;
        #1;
        check_reset_outputs();
        m_phase = 0;
        m_ptr   = 0;
        @(posedge clk_mem);
        #1;
        rstn_mem = 1'b1;
    endtask

    task automatic randomize_bus();
        bus.PC        = 4'($urandom);
        bus.mmadr_mem = 4'($urandom);
        bus.mmwr_mem  = 1'($urandom);
        bus.wdata_mem = 8'($urandom);
    endtask

    // Feed the first n bytes of img; stall mode follows a 1,0,0 valid pattern.
    task automatic load_bytes(input int n, input bit stall);
        int cnt;
        int k;
        cnt = 0;
        k   = 0;
        while (cnt < n && k < 400) begin
            randomize_bus();
            ld_valid = stall ? (k % 3 == 0) : 1'b1;
            ld_data  = ld_valid ? img[cnt] : 8'($urandom);
            step();
            if (ld_valid) cnt++;
            k++;
        end
        check("load_budget", cnt, n);
        ld_valid = 1'b0;
    endtask

    task automatic read_all_vs_img(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus.PC       = 4'(a);
            bus.mmwr_mem = 1'b0;
            ld_valid     = 1'b1;
            ld_data      = 8'($urandom);
            step();
            check(tag, {24'h0, bus.INSTRUCTION}, {24'h0, img[a]});
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_mem      = 1'b1;
        ld_valid      = 1'b0;
        ld_data       = 8'h00;
        bus.PC        = 4'h0;
        bus.mmadr_mem = 4'h0;
        bus.mmwr_mem  = 1'b0;
        bus.wdata_mem = 8'h00;
        m_phase       = 0;
        m_ptr         = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        #2;
        rstn_mem = 1'b0;
        repeat (2) @(posedge clk_mem);
        #1;
        check_reset_outputs();
        rstn_mem = 1'b1;

        // Boot load with ld_valid held high, stores attempted throughout
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        img[0] = 8'h50;
        img[1] = 8'h00;
        img[2] = 8'h20;
        load_bytes(16, 1'b0);
        bus.mmwr_mem = 1'b0;
        bus.PC       = 4'd0;
        step();
        check("boot_pc0", {24'h0, bus.INSTRUCTION}, 32'h50);
        bus.PC = 4'd2;
        step();
        check("boot_pc2", {24'h0, bus.INSTRUCTION}, 32'h20);
        read_all_vs_img("image_a");

        // Store then fetch
        bus.mmadr_mem = 4'd9;
        bus.wdata_mem = 8'hA5;
        bus.mmwr_mem  = 1'b1;
        bus.PC        = 4'd0;
        step();
        bus.mmwr_mem = 1'b0;
        bus.PC       = 4'd9;
        step();
        check("store9", {24'h0, bus.INSTRUCTION}, 32'hA5);

        // Collision is write-first; a different store address leaves the fetch alone
        bus.PC        = 4'd3;
        bus.mmadr_mem = 4'd3;
        bus.wdata_mem = 8'h3C;
        bus.mmwr_mem  = 1'b1;
        step();
        check("coll_same", {24'h0, bus.INSTRUCTION}, 32'h3C);
        bus.mmadr_mem = 4'd4;
        bus.wdata_mem = 8'hC3;
        step();
        check("coll_diff", {24'h0, bus.INSTRUCTION}, 32'h3C);
        bus.mmwr_mem = 1'b0;
        bus.PC       = 4'd4;
        step();
        check("coll_store4", {24'h0, bus.INSTRUCTION}, 32'hC3);

        // Random run traffic with loader activity that must be ignored
        for (int i = 0; i < 300; i++) begin
            randomize_bus();
            ld_valid = 1'($urandom);
            ld_data  = 8'($urandom);
            step();
        end
        ld_valid = 1'b0;

        // Reset during RUN, partial load, reset mid-load, then full stalled load
        do_reset();
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        load_bytes(5, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        load_bytes(16, 1'b1);
        bus.mmwr_mem = 1'b0;
        bus.PC       = 4'($urandom);
        step();
        read_all_vs_img("image_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
